// File: rtl/proc_pkg.sv
// Shared fetch-side types: program-counter and instruction widths plus the queue entry payload.
package proc_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fq_entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// Small synchronous FIFO of fetched instructions with flush.
// The head entry is read directly from storage, so there is no bypass from push to head.
module ipq_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fq_entry_t     wdata,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero until the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: issues ROM reads, absorbs the 1-cycle ROM latency and
// queues instructions for decode, with a full flush on a taken redirect.
module inst_prefetch_queue
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectTarget,
  output logic               FetchEn,
  output logic [PC_W-1:0]    FetchAddr,
  input  logic [INSTR_W-1:0] FetchData,
  output logic               InstValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstPC,
  input  logic               InstReady
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;

  pc_t           fetch_ptr;
  pc_t           inflight_pc;
  logic          inflight;
  logic [CW-1:0] q_count;
  fq_entry_t     q_head;
  fq_entry_t     q_wdata;
  logic          q_push;
  logic          q_pop;
  logic          has_credit;

  // A slot is reserved for the outstanding read so a capture can never overflow the queue.
  assign has_credit = (CRW'(q_count) + CRW'(inflight)) < CRW'(DEPTH);
  assign FetchEn    = Reset && !Start && !Redirect && has_credit;
  assign FetchAddr  = fetch_ptr;

  // A response landing in the redirect cycle belongs to the old path and is dropped.
  assign q_push  = inflight && !Redirect;
  assign q_pop   = InstValid && InstReady;
  assign q_wdata = '{instr: FetchData, pc: inflight_pc};

  assign InstValid = (q_count != '0);
  assign Instr     = q_head.instr;
  assign InstPC    = q_head.pc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_ptr   <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (Redirect) begin
      fetch_ptr <= RedirectTarget;
      inflight  <= 1'b0;
    end else begin
      inflight <= FetchEn;
      if (FetchEn) begin
        fetch_ptr   <= fetch_ptr + PC_W'(1);
        inflight_pc <= fetch_ptr;
      end
    end
  end

  ipq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (Redirect),
    .wdata (q_wdata),
    .head  (q_head),
    .count (q_count)
  );

endmodule
